pixel_frame_loader: RTL and testbench
=====================================

Name: pixel_frame_loader

Overview:
- Upstream ingest stage for the defect-detection inference top level.
- Accepts a pixel stream, one pixel per beat with a valid/ready handshake, and assembles it into the flattened frame bus that the inference datapath consumes.
- Holds the frame stable for a fixed settle window, then latches the single-bit inference result and flags it.
- Detects short and long frames and discards them.

Parameters:
INPUT_SIZE, 4096, pixels per frame
DATA_WIDTH, 8, bits per pixel
SETTLE_CYCLES, 4, cycles the frame is held stable before the result is sampled (must be >= 1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
s_pixel  input  DATA_WIDTH  pixel value of the current beat
s_valid  input  1  beat valid
s_last  input  1  marks the final pixel of a frame
s_ready  output  1  loader can accept a beat
pixel_data_flat  output  DATA_WIDTH*INPUT_SIZE  assembled frame; pixel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
frame_valid  output  1  pixel_data_flat holds a complete, stable frame
inference_in  input  1  binary result from the inference datapath
result  output  1  latched inference result
result_valid  output  1  one-cycle pulse when result is updated
frame_error  output  1  one-cycle pulse on a short or long frame

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FILL, beat counter=0, settle counter=0.
  - pixel_data_flat=0, frame_valid=0, result=0, result_valid=0, frame_error=0.
  - s_ready=0 while rst=0.
  - A reset mid-frame or mid-settle discards all progress; no result_valid is produced.
- Handshake: a beat transfers when s_valid && s_ready. s_valid may be held with no transfer; the loader ignores s_pixel/s_last when no transfer occurs.
- States: FILL, DRAIN, SETTLE.
- FILL: s_ready=1.
  - On each transfer, write s_pixel into lane cnt and increment cnt. cnt is $clog2(INPUT_SIZE) bits wide, minimum 1.
  - Transfer with cnt==INPUT_SIZE-1 and s_last=1: go to SETTLE, frame_valid=1 from the next cycle, cnt=0.
  - Transfer with cnt==INPUT_SIZE-1 and s_last=0 (long frame): frame_error pulse, go to DRAIN, cnt=0.
  - Transfer with s_last=1 and cnt<INPUT_SIZE-1 (short frame): frame_error pulse, cnt=0, stay in FILL. Partially written lanes are not cleared.
- DRAIN: s_ready=1; beats are discarded; lanes are not written. A transfer with s_last=1 returns the block to FILL. No second frame_error is raised.
- SETTLE: s_ready=0; pixel_data_flat is frozen; the settle counter increments each cycle from 0.
  - When settle==SETTLE_CYCLES-1: result<=inference_in, result_valid=1 on the next cycle, frame_valid=0 on the next cycle, state=FILL.
- Latency: last beat accepted in cycle T.
  - frame_valid high in cycles T+1..T+SETTLE_CYCLES.
  - inference_in sampled at the edge ending cycle T+SETTLE_CYCLES.
  - result_valid high in cycle T+SETTLE_CYCLES+1, and s_ready=1 in the same cycle.
  - Back-to-back frames lose exactly SETTLE_CYCLES cycles of throughput.
- pixel_data_flat retains the previous frame outside SETTLE; lanes are overwritten progressively. Consumers must qualify it with frame_valid.
- result holds its value until the next successful frame.
- INPUT_SIZE=1: every beat is the last pixel; a beat with s_last=0 is a long frame.

Decomposition:
- Package pixel_loader_pkg holds:
  - the state enum (FILL, DRAIN, SETTLE);
  - localparam CNT_W=$clog2(INPUT_SIZE) (minimum 1);
  - localparam SETTLE_W=$clog2(SETTLE_CYCLES+1).
- One sub-module, loader_beat_counter: wrapping counter with clear, enable and terminal-count flag. It is instanced twice, once for the beat index and once for the settle timer.

Test Plan (INPUT_SIZE=16, DATA_WIDTH=8, SETTLE_CYCLES=4 unless stated):
- Directed frame, pixel i = 8'h10+i, s_last on beat 15, inference_in=1 -> frame_valid high for 4 cycles; pixel_data_flat[7:0]=8'h10 and [127:120]=8'h1F; result=1 with a single-cycle result_valid at T+5; s_ready low during SETTLE.
- Short frame, s_last on beat 9 -> frame_error pulses once at the cycle after beat 9; no frame_valid; the next full frame of all 8'hAA loads correctly and produces result_valid.
- Long frame, 20 beats with s_last on beat 19 -> frame_error pulses once after beat 15; beats 16-19 are accepted but not written; the block is in FILL afterwards; a subsequent frame succeeds.
- Random s_valid gaps (about 50% duty) on a full frame -> contents identical to the gapless case; latency measured from the last accepted beat is unchanged.
- rst pulsed low after beat 7, then again during SETTLE cycle 2 -> all outputs return to reset values immediately; no result_valid is produced; a fresh frame afterwards completes normally.
- Two back-to-back frames with inference_in=0 then 1 -> result_valid pulses exactly twice, 16+4 cycles apart, with result=0 then 1.

Source files
------------

// File: rtl/pixel_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_loader_pkg
// Description : Shared types, sizing helpers and default widths for the
//               pixel frame loader.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_loader_pkg;

    // Default frame geometry; instances size themselves from their own
    // parameters through the helper functions below.
    localparam int C_INPUT_SIZE    = 4096;
    localparam int C_SETTLE_CYCLES = 4;

    // Beat index width, never narrower than one bit.
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Settle timer width, wide enough to hold SETTLE_CYCLES itself.
    function automatic int f_settle_w(input int s);
        return (s > 0) ? $clog2(s + 1) : 1;
    endfunction

    localparam int CNT_W    = f_cnt_w(C_INPUT_SIZE);
    localparam int SETTLE_W = f_settle_w(C_SETTLE_CYCLES);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/loader_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : loader_beat_counter
// Description : Wrapping up-counter with synchronous clear, count enable and
//               a terminal-count flag (count == MAX-1).
// Revision    : 1.0 - initial release
// ============================================================================
module loader_beat_counter
    import pixel_loader_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int MAX   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_tc    = (r_count == c_last);

    // Count up on enable, wrapping to zero after the terminal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_loader
// Description : Assembles a valid/ready pixel stream into a flat frame bus,
//               holds it for a settle window, then latches the inference
//               result. Short and long frames are flagged and discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_loader
    import pixel_loader_pkg::*;
#(
    parameter int INPUT_SIZE    = 4096,
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_pixel,
    input  logic                             s_valid,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic [DATA_WIDTH*INPUT_SIZE-1:0] pixel_data_flat,
    output logic                             frame_valid,
    input  logic                             inference_in,
    output logic                             result,
    output logic                             result_valid,
    output logic                             frame_error
);

    localparam int c_cnt_w    = f_cnt_w(INPUT_SIZE);
    localparam int c_settle_w = f_settle_w(SETTLE_CYCLES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_lane [INPUT_SIZE];
    logic                    r_result;
    logic                    r_result_valid;
    logic                    r_frame_error;

    logic                    w_ready;
    logic                    w_xfer;
    logic                    w_fill_xfer;
    logic                    w_beat_tc;
    logic [c_cnt_w-1:0]      w_beat_cnt;
    logic                    w_settle_tc;
    logic                    w_settle_done;
    // Only the terminal count of the settle timer drives the FSM.
    logic [c_settle_w-1:0]   w_settle_cnt_unused;

    // Reset forces s_ready low even though the state already reads FILL.
    assign w_ready       = (r_state != SETTLE);
    assign s_ready       = w_ready & rst;
    assign w_xfer        = s_valid & s_ready;
    assign w_fill_xfer   = w_xfer & (r_state == FILL);
    assign w_settle_done = (r_state == SETTLE) & w_settle_tc;

    assign frame_valid   = (r_state == SETTLE);
    assign result        = r_result;
    assign result_valid  = r_result_valid;
    assign frame_error   = r_frame_error;

    // Beat index: cleared on any s_last in FILL so a short frame restarts at lane 0.
    loader_beat_counter #(
        .WIDTH (c_cnt_w),
        .MAX   (INPUT_SIZE)
    ) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_fill_xfer & s_last),
        .i_en    (w_fill_xfer),
        .o_count (w_beat_cnt),
        .o_tc    (w_beat_tc)
    );

    // Settle timer: held at zero outside SETTLE, runs 0..SETTLE_CYCLES-1 inside.
    loader_beat_counter #(
        .WIDTH (c_settle_w),
        .MAX   (SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (r_state != SETTLE),
        .i_en    (r_state == SETTLE),
        .o_count (w_settle_cnt_unused),
        .o_tc    (w_settle_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: full frame -> SETTLE, overlong frame -> DRAIN until s_last.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (w_fill_xfer && w_beat_tc) begin
                    w_state_nxt = s_last ? SETTLE : DRAIN;
                end
            end
            DRAIN: begin
                if (w_xfer && s_last) begin
                    w_state_nxt = FILL;
                end
            end
            SETTLE: begin
                if (w_settle_tc) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Frame lanes: written only by accepted FILL beats; retained otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                if (w_fill_xfer && (w_beat_cnt == c_cnt_w'(i))) begin
                    r_lane[i] <= s_pixel;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_flat
            assign pixel_data_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_lane[g];
        end
    endgenerate

    // Result capture at end of settle; frame_error when s_last disagrees with the terminal beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result       <= 1'b0;
            r_result_valid <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_result_valid <= w_settle_done;
            r_frame_error  <= w_fill_xfer & (w_beat_tc ^ s_last);
            if (w_settle_done) begin
                r_result <= inference_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_frame_loader
// Description : Directed self-checking bench for pixel_frame_loader
//               (16 pixels x 8 bits, 4 settle cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_loader;

    localparam int INPUT_SIZE    = 16;
    localparam int DATA_WIDTH    = 8;
    localparam int SETTLE_CYCLES = 4;
    localparam int FW            = INPUT_SIZE * DATA_WIDTH;

    logic          clk;
    logic          rst;
    logic [7:0]    s_pixel;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [FW-1:0] pixel_data_flat;
    logic          frame_valid;
    logic          inference_in;
    logic          result;
    logic          result_valid;
    logic          frame_error;

    pixel_frame_loader #(
        .INPUT_SIZE    (INPUT_SIZE),
        .DATA_WIDTH    (DATA_WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .s_pixel         (s_pixel),
        .s_valid         (s_valid),
        .s_last          (s_last),
        .s_ready         (s_ready),
        .pixel_data_flat (pixel_data_flat),
        .frame_valid     (frame_valid),
        .inference_in    (inference_in),
        .result          (result),
        .result_valid    (result_valid),
        .frame_error     (frame_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Event monitor, sampled mid-cycle on the falling edge.
    int cyc = 0;
    int n_rv, n_fe, n_fv, n_fv_rdy, last_xfer, fe_cyc, rv_rdy;
    int rv_cyc[$];
    int rv_res[$];

    always @(negedge clk) begin
        cyc++;
        if (s_valid && s_ready) last_xfer = cyc;
        if (result_valid) begin
            n_rv++;
            rv_cyc.push_back(cyc);
            rv_res.push_back(int'(result));
            rv_rdy = int'(s_ready);
        end
        if (frame_error) begin
            n_fe++;
            fe_cyc = cyc;
        end
        if (frame_valid) begin
            n_fv++;
            if (s_ready) n_fv_rdy++;
        end
    end

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_rv = 0; n_fe = 0; n_fv = 0; n_fv_rdy = 0;
        last_xfer = -100; fe_cyc = -100; rv_rdy = -1;
        rv_cyc.delete();
        rv_res.delete();
    endtask

    function automatic logic [FW-1:0] exp_frame(input logic [7:0] base, input int step);
        logic [FW-1:0] e;
        for (int i = 0; i < INPUT_SIZE; i++) e[i*8 +: 8] = base + 8'(i * step);
        return e;
    endfunction

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [7:0] pix, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_pixel = pix;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("beat_accept_wait", (n < 50), 1'b1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int step, input int nbeats,
                              input int last_idx, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(base + 8'(i * step), (i == last_idx));
        end
    endtask

    task automatic wait_rv(input int target);
        for (int k = 0; k < 100 && n_rv < target; k++) @(negedge clk);
        check("rv_seen", n_rv, target);
    endtask

    int b15;

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_pixel = '0; s_last = 1'b0; inference_in = 1'b0;
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_ready, 1'b0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_result", result, 1'b0);
        check("rst_rv", result_valid, 1'b0);
        check("rst_fe", frame_error, 1'b0);
        check("rst_flat", pixel_data_flat, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed frame, inference 1
        clear_mon();
        inference_in = 1'b1;
        send_frame(8'h10, 1, 16, 15, 1'b0);
        wait_rv(1);
        repeat (4) @(negedge clk);
        check("d_lane0", pixel_data_flat[7:0], 8'h10);
        check("d_lane15", pixel_data_flat[127:120], 8'h1F);
        check("d_flat", pixel_data_flat, exp_frame(8'h10, 1));
        check("d_fv_cycles", n_fv, 4);
        check("d_ready_in_settle", n_fv_rdy, 0);
        check("d_latency", rv_cyc[0] - last_xfer, 5);
        check("d_rv_ready", rv_rdy, 1);
        check("d_rv_count", n_rv, 1);
        check("d_result", result, 1'b1);
        check("d_no_fe", n_fe, 0);

        // Short frame, then all-AA frame with inference 0
        @(posedge clk); #1;
        clear_mon();
        send_frame(8'h50, 1, 10, 9, 1'b0);
        repeat (3) @(negedge clk);
        check("s_fe_count", n_fe, 1);
        check("s_fe_cycle", fe_cyc - last_xfer, 1);
        check("s_no_fv", n_fv, 0);
        check("s_no_rv", n_rv, 0);
        @(posedge clk); #1;
        inference_in = 1'b0;
        send_frame(8'hAA, 0, 16, 15, 1'b0);
        wait_rv(1);
        repeat (3) @(negedge clk);
        check("s_aa_flat", pixel_data_flat, exp_frame(8'hAA, 0));
        check("s_aa_result", result, 1'b0);
        check("s_aa_fe", n_fe, 1);

        // Long frame: 20 beats, s_last on beat 19
        @(posedge clk); #1;
        clear_mon();
        send_frame(8'hC0, 1, 16, -1, 1'b0);
        b15 = last_xfer;
        for (int i = 16; i < 20; i++) send_beat(8'hC0 + 8'(i), (i == 19));
        repeat (3) @(negedge clk);
        check("l_fe_count", n_fe, 1);
        check("l_fe_cycle", fe_cyc - b15, 1);
        check("l_flat_unwritten", pixel_data_flat, exp_frame(8'hC0, 1));
        check("l_no_fv", n_fv, 0);
        check("l_no_rv", n_rv, 0);
        @(posedge clk); #1;
        inference_in = 1'b1;
        send_frame(8'h20, 1, 16, 15, 1'b0);
        wait_rv(1);
        repeat (3) @(negedge clk);
        check("l_next_flat", pixel_data_flat, exp_frame(8'h20, 1));
        check("l_next_result", result, 1'b1);

        // Gapped frame, inference 1
        @(posedge clk); #1;
        clear_mon();
        inference_in = 1'b1;
        send_frame(8'h60, 3, 16, 15, 1'b1);
        wait_rv(1);
        repeat (3) @(negedge clk);
        check("g_flat", pixel_data_flat, exp_frame(8'h60, 3));
        check("g_latency", rv_cyc[0] - last_xfer, 5);
        check("g_fv_cycles", n_fv, 4);
        check("g_result", result, 1'b1);

        // Reset after beat 7
        @(posedge clk); #1;
        clear_mon();
        send_frame(8'h77, 1, 8, -1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("r1_flat", pixel_data_flat, '0);
        check("r1_ready", s_ready, 1'b0);
        check("r1_result", result, 1'b0);
        check("r1_fv", frame_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset during settle cycle 2
        @(posedge clk); #1;
        send_frame(8'h30, 1, 16, 15, 1'b0);
        clear_mon();
        @(negedge clk);
        @(negedge clk);
        check("r2_in_settle", frame_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("r2_fv", frame_valid, 1'b0);
        check("r2_flat", pixel_data_flat, '0);
        check("r2_ready", s_ready, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("r2_no_rv", n_rv, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        inference_in = 1'b1;
        send_frame(8'h40, 2, 16, 15, 1'b0);
        wait_rv(1);
        repeat (3) @(negedge clk);
        check("r_fresh_flat", pixel_data_flat, exp_frame(8'h40, 2));
        check("r_fresh_result", result, 1'b1);

        // Back-to-back frames, inference 0 then 1
        @(posedge clk); #1;
        clear_mon();
        inference_in = 1'b0;
        fork
            begin
                send_frame(8'h01, 1, 16, 15, 1'b0);
                send_frame(8'h81, 1, 16, 15, 1'b0);
            end
            begin
                for (int k = 0; k < 200 && n_rv < 1; k++) @(negedge clk);
                inference_in = 1'b1;
            end
        join
        wait_rv(2);
        repeat (4) @(negedge clk);
        check("b_rv_count", n_rv, 2);
        check("b_spacing", rv_cyc[1] - rv_cyc[0], 20);
        check("b_res0", rv_res[0], 0);
        check("b_res1", rv_res[1], 1);
        check("b_flat", pixel_data_flat, exp_frame(8'h81, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
